// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the byte-wide IP TX path between NUM_REQ requesters.
// Prepends an 8-byte UDP header (checksum 0) and streams the payload under ready/valid.
module udp_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter logic [15:0] SRC_PORT_BASE = 16'd50000,
  parameter int unsigned MAX_PAYLOAD   = 1472,
  parameter int unsigned IFG_CYCLES    = 2
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rstn,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [16*NUM_REQ-1:0]  i_req_len,
  input  logic [16*NUM_REQ-1:0]  i_dst_port,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_pull,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [NUM_REQ-1:0]     o_reject,
  output logic                   o_ip_vld,
  output logic [7:0]             o_ip_data,
  output logic                   o_ip_last,
  output logic [15:0]            o_ip_len,
  input  logic                   i_ip_ready,
  input  logic                   i_ip_abort
);

  localparam int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned GapInit = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam logic [15:0] MaxLen  = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StGap} state_e;

  state_e          state_q;
  logic [PtrW-1:0] rr_q;
  logic [PtrW-1:0] sel_q;
  logic [15:0]     dst_q;
  logic [15:0]     cnt_q;  // index of the next datagram byte to load
  logic [GapW-1:0] gap_q;

  logic [15:0] req_len  [NUM_REQ];
  logic [15:0] req_dst  [NUM_REQ];
  logic [7:0]  req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_len[g]  = i_req_len[16*g +: 16];
    assign req_dst[g]  = i_dst_port[16*g +: 16];
    assign req_data[g] = i_req_data[8*g +: 8];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PtrW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan from rr_q+1 upward, wrapping, first pending requester wins.
  logic            win_vld;
  logic [PtrW-1:0] win_idx;
  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && i_req[PtrW'(idx)]) begin
        win_vld = 1'b1;
        win_idx = PtrW'(idx);
      end
    end
  end

  logic [15:0] win_len;
  logic [15:0] src_win;
  logic [15:0] src_sel;
  logic [7:0]  hdr_byte;
  logic [7:0]  next_byte;
  logic        busy;
  logic        load_en;

  always_comb begin
    win_len  = req_len[win_idx];
    src_win  = SRC_PORT_BASE + 16'(win_idx);
    src_sel  = SRC_PORT_BASE + 16'(sel_q);
    hdr_byte = 8'h00;
    case (cnt_q[2:0])
      3'd0:    hdr_byte = src_sel[15:8];
      3'd1:    hdr_byte = src_sel[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = o_ip_len[15:8];
      3'd5:    hdr_byte = o_ip_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
    next_byte = (state_q == StPayload) ? req_data[sel_q] : hdr_byte;
    busy      = (state_q == StHeader) || (state_q == StPayload);
    // A pending last byte is never replaced; completion handles it instead.
    load_en   = busy && (!o_ip_vld || i_ip_ready) && !o_ip_last && !i_ip_abort;
  end

  assign o_pull = (load_en && (state_q == StPayload)) ? onehot(sel_q) : '0;

  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      rr_q      <= PtrW'(NUM_REQ - 1);
      sel_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      o_grant   <= '0;
      o_done    <= '0;
      o_reject  <= '0;
      o_ip_vld  <= 1'b0;
      o_ip_data <= '0;
      o_ip_last <= 1'b0;
      o_ip_len  <= '0;
    end else begin
      o_done   <= '0;
      o_reject <= '0;
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            rr_q <= win_idx;
            if (win_len > MaxLen) begin
              o_reject <= onehot(win_idx);
            end else begin
              sel_q     <= win_idx;
              dst_q     <= req_dst[win_idx];
              cnt_q     <= 16'd1;
              o_grant   <= onehot(win_idx);
              o_ip_vld  <= 1'b1;
              o_ip_data <= src_win[15:8];
              o_ip_last <= 1'b0;
              o_ip_len  <= win_len + 16'd8;
              state_q   <= StHeader;
            end
          end
        end
        StHeader, StPayload: begin
          if (i_ip_abort || (o_ip_vld && i_ip_ready && o_ip_last)) begin
            o_grant   <= '0;
            o_ip_vld  <= 1'b0;
            o_ip_data <= '0;
            o_ip_last <= 1'b0;
            o_ip_len  <= '0;
            if (i_ip_abort) begin
              state_q <= StIdle;
            end else begin
              o_done  <= onehot(sel_q);
              gap_q   <= GapW'(GapInit);
              state_q <= (IFG_CYCLES == 0) ? StIdle : StGap;
            end
          end else if (load_en) begin
            o_ip_vld  <= 1'b1;
            o_ip_data <= next_byte;
            o_ip_last <= (cnt_q == o_ip_len - 16'd1);
            cnt_q     <= cnt_q + 16'd1;
            if (cnt_q == 16'd7 && o_ip_len != 16'd8) state_q <= StPayload;
          end
        end
        StGap: begin
          if (gap_q == '0) state_q <= StIdle;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized self-checking bench for udp_tx_arbiter: a monitor logs accepted bytes and
// pulses, and each scenario compares them against datagrams rebuilt from the UDP rules.
module tb_udp_tx_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned IFG  = 2;
  localparam int unsigned MAXP = 1472;
  localparam logic [15:0] SRC  = 16'd50000;

  logic           i_sys_clk = 1'b0;
  logic           i_rstn;
  logic [N-1:0]   i_req;
  logic [16*N-1:0] i_req_len;
  logic [16*N-1:0] i_dst_port;
  logic [8*N-1:0] i_req_data;
  logic [N-1:0]   o_grant, o_pull, o_done, o_reject;
  logic           o_ip_vld, o_ip_last, i_ip_ready, i_ip_abort;
  logic [7:0]     o_ip_data;
  logic [15:0]    o_ip_len;

  always #5 i_sys_clk = ~i_sys_clk;

  udp_tx_arbiter #(
    .NUM_REQ(N), .SRC_PORT_BASE(SRC), .MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFG)
  ) dut (
    .i_sys_clk(i_sys_clk), .i_rstn(i_rstn), .i_req(i_req), .i_req_len(i_req_len),
    .i_dst_port(i_dst_port), .i_req_data(i_req_data), .o_grant(o_grant), .o_pull(o_pull),
    .o_done(o_done), .o_reject(o_reject), .o_ip_vld(o_ip_vld), .o_ip_data(o_ip_data),
    .o_ip_last(o_ip_last), .o_ip_len(o_ip_len), .i_ip_ready(i_ip_ready),
    .i_ip_abort(i_ip_abort)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Requester FIFOs: first-word-fall-through payload per requester.
  logic [7:0] pay_mem [N][64];
  int         pay_rd [N];
  int         pay_wr [N];

  logic [7:0]   acc_data[$];
  logic         acc_last[$];
  int           acc_cyc[$];
  logic [N-1:0] acc_grant[$];
  logic [15:0]  acc_len[$];
  int           done_k[$], done_cyc[$], rej_k[$], rej_cyc[$];
  int           pull_cnt [N];
  logic         grant_seen, vld_seen, prev_stall;
  logic [9:0]   prev_out;
  int           stall_pull_errs, hold_errs;
  logic [7:0]   exp_q[$];
  logic         exp_last[$];

  task automatic drive_data();
    for (int k = 0; k < N; k++)
      i_req_data[8*k +: 8] = (pay_rd[k] < pay_wr[k]) ? pay_mem[k][pay_rd[k]] : 8'h00;
  endtask

  task automatic clear_logs();
    acc_data.delete(); acc_last.delete(); acc_cyc.delete(); acc_grant.delete();
    acc_len.delete(); done_k.delete(); done_cyc.delete(); rej_k.delete(); rej_cyc.delete();
    exp_q.delete(); exp_last.delete();
    for (int k = 0; k < N; k++) pull_cnt[k] = 0;
    grant_seen = 0; vld_seen = 0; prev_stall = 0; prev_out = '0;
    stall_pull_errs = 0; hold_errs = 0;
  endtask

  // Sample one cycle at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [N-1:0] pulls;
    @(negedge i_sys_clk);
    pulls = o_pull;
    if (o_ip_vld) vld_seen = 1;
    if (|o_grant) grant_seen = 1;
    if (|o_pull && !(o_ip_vld && i_ip_ready)) stall_pull_errs++;
    if (prev_stall && ({o_ip_vld, o_ip_last, o_ip_data} !== prev_out)) hold_errs++;
    prev_stall = o_ip_vld && !i_ip_ready && !i_ip_abort;
    prev_out   = {o_ip_vld, o_ip_last, o_ip_data};
    if (o_ip_vld && i_ip_ready && !i_ip_abort) begin
      acc_data.push_back(o_ip_data); acc_last.push_back(o_ip_last);
      acc_cyc.push_back(cyc); acc_grant.push_back(o_grant); acc_len.push_back(o_ip_len);
    end
    for (int k = 0; k < N; k++) begin
      if (o_done[k]) begin done_k.push_back(k); done_cyc.push_back(cyc); end
      if (o_reject[k]) begin rej_k.push_back(k); rej_cyc.push_back(cyc); end
      pull_cnt[k] += int'(pulls[k]);
    end
    @(posedge i_sys_clk);
    #1;
    for (int k = 0; k < N; k++) if (pulls[k]) pay_rd[k]++;
    drive_data();
    cyc++;
  endtask

  task automatic do_reset();
    i_rstn = 0; i_req = '0; i_req_len = '0; i_dst_port = '0; i_ip_ready = 1; i_ip_abort = 0;
    for (int k = 0; k < N; k++) begin pay_rd[k] = 0; pay_wr[k] = 0; end
    drive_data();
    repeat (2) @(posedge i_sys_clk);
    #1 i_rstn = 1;
    clear_logs();
  endtask

  task automatic send(input int k, input int len, input logic [15:0] dst, output int start);
    start = pay_wr[k];
    i_req_len[16*k +: 16]  = 16'(len);
    i_dst_port[16*k +: 16] = dst;
    for (int i = 0; i < len; i++) begin
      pay_mem[k][pay_wr[k]] = 8'($urandom);
      pay_wr[k]++;
    end
    drive_data();
  endtask

  // Reference datagram: UDP header (src, dst, length, zero checksum) then payload.
  task automatic expect_dgram(input int k, input int len, input logic [15:0] dst,
                              input int start);
    logic [15:0] src, ul;
    logic [7:0]  hdr [8];
    src = SRC + 16'(k);
    ul  = 16'(len + 8);
    hdr = '{src[15:8], src[7:0], dst[15:8], dst[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(hdr[i]); exp_last.push_back(len == 0 && i == 7);
    end
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay_mem[k][start + i]); exp_last.push_back(i == len - 1);
    end
  endtask

  task automatic count_mismatch(output int m);
    m = 0;
    if (acc_data.size() != exp_q.size()) m++;
    for (int i = 0; i < acc_data.size() && i < exp_q.size(); i++)
      if (acc_data[i] !== exp_q[i] || acc_last[i] !== exp_last[i]) m++;
  endtask

  task automatic run_until(input int ndone, input int budget, input int mode,
                           output bit timed_out);
    int p = 0;
    timed_out = 1;
    for (int n = 0; n < budget; n++) begin
      case (mode)
        1:       i_ip_ready = (p % 4 == 0) || (p % 4 == 3);
        2:       i_ip_ready = 1'($urandom_range(0, 1));
        default: i_ip_ready = 1'b1;
      endcase
      p++;
      tick();
      if (done_k.size() >= ndone) begin timed_out = 0; break; end
    end
    i_ip_ready = 1;
  endtask

  task automatic test_reset();
    i_rstn = 0; i_req = '1; i_req_len = '0; i_dst_port = '0; i_ip_ready = 1; i_ip_abort = 0;
    for (int k = 0; k < N; k++) begin pay_rd[k] = 0; pay_wr[k] = 0; end
    drive_data();
    #1;
    checks++;
    if ({o_grant, o_pull, o_done, o_reject, o_ip_vld, o_ip_last, o_ip_data, o_ip_len} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got grant=%b vld=%b data=%h len=%h want all zero",
               o_grant, o_ip_vld, o_ip_data, o_ip_len);
    end
    do_reset();
    tick();
    checks++;
    if (o_ip_vld !== 1'b0 || o_grant !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got vld=%b grant=%b want 0", o_ip_vld, o_grant);
    end
  endtask

  task automatic test_single();
    int st, c0, m, bad_grant;
    bit to;
    do_reset();
    send(0, 3, 16'h1F90, st);
    pay_mem[0][st] = 8'hA1; pay_mem[0][st+1] = 8'hA2; pay_mem[0][st+2] = 8'hA3;
    drive_data();
    expect_dgram(0, 3, 16'h1F90, st);
    c0 = cyc;
    i_req[0] = 1;
    run_until(1, 40, 0, to);
    i_req = '0;
    checks++;
    if (to) begin failures++; $display("FAIL single_timeout: got no done want done"); end
    count_mismatch(m);
    checks++;
    if (m !== 0) begin
      failures++;
      $display("FAIL single_stream: mismatches=%0d got %0d bytes want %0d", m,
               acc_data.size(), exp_q.size());
    end
    if (acc_data.size() == 11) begin
      checks++;
      if (acc_data[0] !== 8'hC3 || acc_data[5] !== 8'h0B || acc_data[10] !== 8'hA3) begin
        failures++;
        $display("FAIL single_bytes: got %h %h %h want c3 0b a3", acc_data[0], acc_data[5],
                 acc_data[10]);
      end
      checks++;
      if (acc_cyc[0] !== c0 + 1) begin
        failures++;
        $display("FAIL single_latency: got cycle %0d want %0d", acc_cyc[0], c0 + 1);
      end
      checks++;
      if (acc_len[0] !== 16'd11) begin
        failures++; $display("FAIL single_ip_len: got %0d want 11", acc_len[0]);
      end
      bad_grant = 0;
      foreach (acc_grant[i]) if (acc_grant[i] !== 4'b0001) bad_grant++;
      checks++;
      if (bad_grant !== 0) begin
        failures++; $display("FAIL single_grant: got %0d bad bytes want 0", bad_grant);
      end
      checks++;
      if (done_k.size() != 1 || done_k[0] !== 0 || done_cyc[0] !== acc_cyc[10] + 1) begin
        failures++;
        $display("FAIL single_done: got %0d pulses want 1 at cycle %0d", done_k.size(),
                 acc_cyc[10] + 1);
      end
    end
    checks++;
    if (pull_cnt[0] !== 3) begin
      failures++; $display("FAIL single_pulls: got %0d want 3", pull_cnt[0]);
    end
  endtask

  task automatic test_round_robin();
    int st [N];
    int st0b, ptr, m, gap_bad, order_bad;
    int ord [5];
    bit seen0, to;
    do_reset();
    for (int k = 0; k < N; k++) send(k, 1, 16'h1000 + 16'(k), st[k]);
    send(0, 1, 16'h1000, st0b);
    ptr = N - 1;
    seen0 = 0;
    for (int d = 0; d < 5; d++) begin
      ptr = (ptr + 1) % N;
      ord[d] = ptr;
      expect_dgram(ptr, 1, 16'h1000 + 16'(ptr), (ptr == 0 && seen0) ? st0b : st[ptr]);
      if (ptr == 0) seen0 = 1;
    end
    i_req = '1;
    run_until(5, 200, 0, to);
    i_req = '0;
    checks++;
    if (to) begin failures++; $display("FAIL rr_timeout: got %0d dones want 5", done_k.size()); end
    count_mismatch(m);
    checks++;
    if (m !== 0) begin failures++; $display("FAIL rr_stream: mismatches=%0d want 0", m); end
    order_bad = 0;
    for (int d = 0; d < 5; d++) begin
      if (d >= done_k.size() || done_k[d] !== ord[d]) order_bad++;
      if (9*d >= acc_grant.size() || acc_grant[9*d] !== N'(1 << ord[d])) order_bad++;
    end
    checks++;
    if (order_bad !== 0) begin
      failures++; $display("FAIL rr_order: got %0d misordered grants want 0", order_bad);
    end
    gap_bad = 0;
    for (int d = 1; d < 5; d++)
      if (9*d >= acc_cyc.size() || acc_cyc[9*d] - acc_cyc[9*d-1] != IFG + 2) gap_bad++;
    checks++;
    if (gap_bad !== 0) begin
      failures++; $display("FAIL rr_gap: got %0d wrong gaps want 0 (gap %0d)", gap_bad, IFG + 2);
    end
  endtask

  task automatic test_backpressure();
    int st, m, k2, len2;
    bit to;
    do_reset();
    send(2, 4, 16'hBEEF, st);
    expect_dgram(2, 4, 16'hBEEF, st);
    i_req[2] = 1;
    run_until(1, 100, 1, to);
    i_req = '0;
    k2   = $urandom_range(0, N - 1);
    len2 = $urandom_range(1, 12);
    send(k2, len2, 16'($urandom), st);
    expect_dgram(k2, len2, i_dst_port[16*k2 +: 16], st);
    repeat (3) tick();
    i_req[k2] = 1;
    run_until(2, 300, 2, to);
    i_req = '0;
    checks++;
    if (to) begin failures++; $display("FAIL bp_timeout: got %0d dones want 2", done_k.size()); end
    count_mismatch(m);
    checks++;
    if (m !== 0) begin failures++; $display("FAIL bp_stream: mismatches=%0d want 0", m); end
    checks++;
    if (pull_cnt[2] + ((k2 == 2) ? 0 : pull_cnt[k2]) !== 4 + len2) begin
      failures++;
      $display("FAIL bp_pulls: got %0d want %0d", pull_cnt[2] + ((k2 == 2) ? 0 : pull_cnt[k2]),
               4 + len2);
    end
    checks++;
    if (stall_pull_errs !== 0) begin
      failures++; $display("FAIL bp_pull_stalled: got %0d stalled pulls want 0", stall_pull_errs);
    end
    checks++;
    if (hold_errs !== 0) begin
      failures++; $display("FAIL bp_hold: got %0d changes while stalled want 0", hold_errs);
    end
  endtask

  task automatic test_zero_reject();
    int st, m, c0;
    bit to;
    do_reset();
    send(1, 0, 16'h0444, st);
    expect_dgram(1, 0, 16'h0444, st);
    i_req[1] = 1;
    run_until(1, 40, 0, to);
    i_req = '0;
    count_mismatch(m);
    checks++;
    if (to || m !== 0 || acc_data.size() != 8) begin
      failures++;
      $display("FAIL zero_stream: got %0d bytes mismatches=%0d want 8 bytes 0", acc_data.size(), m);
    end
    checks++;
    if (pull_cnt[1] !== 0) begin failures++; $display("FAIL zero_pulls: got %0d want 0", pull_cnt[1]); end
    repeat (4) tick();
    clear_logs();
    i_req_len[16*2 +: 16] = 16'd1473;
    c0 = cyc;
    i_req[2] = 1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (rej_k.size() > 0) break;
    end
    i_req = '0;
    repeat (5) tick();
    checks++;
    if (rej_k.size() == 0 || rej_k[0] !== 2 || rej_cyc[0] !== c0 + 1) begin
      failures++;
      $display("FAIL reject_pulse: got %0d pulses want one on req 2 at cycle %0d", rej_k.size(),
               c0 + 1);
    end
    checks++;
    if (grant_seen !== 0 || vld_seen !== 0 || done_k.size() != 0) begin
      failures++;
      $display("FAIL reject_quiet: got grant=%b vld=%b want 0 0", grant_seen, vld_seen);
    end
  endtask

  task automatic test_abort();
    int st1, st2, a, m;
    bit to;
    do_reset();
    send(1, 10, 16'h1111, st1);
    send(2, 2, 16'h2222, st2);
    i_req = 4'b0110;
    to = 1;
    for (int n = 0; n < 40; n++) begin
      if (acc_data.size() == 10) begin to = 0; break; end
      tick();
    end
    a = cyc;
    i_ip_abort = 1;
    tick();
    i_ip_abort = 0;
    i_req[1] = 0;
    checks++;
    if (to || {o_grant, o_pull, o_done, o_ip_vld, o_ip_last, o_ip_data, o_ip_len} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got vld=%b grant=%b done=%b want 0", o_ip_vld, o_grant, o_done);
    end
    checks++;
    if (pull_cnt[1] !== 3 || done_k.size() != 0) begin
      failures++;
      $display("FAIL abort_pulls: got %0d pulls %0d dones want 3 0", pull_cnt[1], done_k.size());
    end
    clear_logs();
    expect_dgram(2, 2, 16'h2222, st2);
    run_until(1, 60, 0, to);
    i_req = '0;
    count_mismatch(m);
    checks++;
    if (to || m !== 0 || done_k.size() != 1 || done_k[0] !== 2) begin
      failures++; $display("FAIL abort_next: got mismatches=%0d dones=%0d want 0 1", m, done_k.size());
    end
    checks++;
    if (acc_cyc.size() == 0 || acc_cyc[0] !== a + 2 || acc_grant[0] !== 4'b0100) begin
      failures++; $display("FAIL abort_latency: want req 2 first byte at cycle %0d", a + 2);
    end
  endtask

  task automatic test_reset_mid();
    int st, st0, st3;
    bit to;
    do_reset();
    send(2, 10, 16'h3333, st);
    i_req[2] = 1;
    for (int n = 0; n < 40; n++) begin
      if (acc_data.size() == 11) break;
      tick();
    end
    i_rstn = 0;
    #1;
    checks++;
    if ({o_grant, o_pull, o_done, o_reject, o_ip_vld, o_ip_last, o_ip_data, o_ip_len} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got vld=%b grant=%b pull=%b want 0", o_ip_vld, o_grant,
               o_pull);
    end
    do_reset();
    send(0, 2, 16'h0A0A, st0);
    send(3, 2, 16'h0D0D, st3);
    i_req = 4'b1001;
    run_until(1, 60, 0, to);
    i_req = '0;
    checks++;
    if (to || acc_grant.size() == 0 || acc_grant[0] !== 4'b0001 || done_k[0] !== 0) begin
      failures++; $display("FAIL reset_mid_priority: got first grant not req 0 want 0001");
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    int ks[$];
    int lens [N];
    int k, len, st, m, order_bad, pull_bad;
    bit to, any_to;
    logic [15:0] dst;
    do_reset();
    any_to = 0;
    for (int i = 0; i < N; i++) lens[i] = 0;
    for (int d = 0; d < 6; d++) begin
      k   = $urandom_range(0, N - 1);
      len = $urandom_range(0, 20);
      dst = 16'($urandom);
      pay_rd[k] = 0; pay_wr[k] = 0;
      send(k, len, dst, st);
      expect_dgram(k, len, dst, st);
      ks.push_back(k);
      lens[k] += len;
      i_req[k] = 1;
      run_until(d + 1, 400, 2, to);
      i_req = '0;
      if (to) any_to = 1;
      repeat ($urandom_range(0, 3)) tick();
    end
    count_mismatch(m);
    checks++;
    if (any_to || m !== 0) begin
      failures++; $display("FAIL random_stream: timeout=%0d mismatches=%0d want 0 0", any_to, m);
    end
    order_bad = 0;
    for (int d = 0; d < 6; d++) if (d >= done_k.size() || done_k[d] !== ks[d]) order_bad++;
    pull_bad = 0;
    for (int i = 0; i < N; i++) if (pull_cnt[i] != lens[i]) pull_bad++;
    checks++;
    if (order_bad !== 0 || pull_bad !== 0) begin
      failures++;
      $display("FAIL random_done_pull: got %0d bad dones %0d bad pull counts want 0 0", order_bad,
               pull_bad);
    end
    checks++;
    if (stall_pull_errs !== 0 || hold_errs !== 0) begin
      failures++;
      $display("FAIL random_stall: got %0d stalled pulls %0d hold errors want 0 0",
               stall_pull_errs, hold_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_reject();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
